cnn_window_gen: RTL and testbench

- Frame-buffered neighbourhood generator that feeds the CNN cell datapath.
- Accepts one raster-order frame of cell inputs (U, WIDTH bits) and cell states (Y, 2*WIDTH bits) on a valid/ready stream.
- Replays the frame one cell at a time as a 3x3 neighbourhood: U1..U9 and Y1..Y9, with out-of-array neighbours replaced by fixed boundary values.
- Outputs connect directly to the U/Y inputs of the per-cell template evaluator.

---
 rtl/cnn_window_gen.sv | 195 +++++++++++++++++++
 tb/tb_cnn_window_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: buffers one raster-order frame of {U,Y} cell values and
// replays it as registered 3x3 neighbourhoods, one centre cell per window,
// substituting BOUND_U / BOUND_Y for neighbours outside the cell array.
module cnn_window_gen #(
    parameter int WIDTH = 9,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter logic signed [WIDTH-1:0]   BOUND_U = '0,
    parameter logic signed [2*WIDTH-1:0] BOUND_Y = '0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_u,
    input  logic [2*WIDTH-1:0]   s_y,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WIDTH-1:0]     U1,
    output logic [WIDTH-1:0]     U2,
    output logic [WIDTH-1:0]     U3,
    output logic [WIDTH-1:0]     U4,
    output logic [WIDTH-1:0]     U5,
    output logic [WIDTH-1:0]     U6,
    output logic [WIDTH-1:0]     U7,
    output logic [WIDTH-1:0]     U8,
    output logic [WIDTH-1:0]     U9,
    output logic [2*WIDTH-1:0]   Y1,
    output logic [2*WIDTH-1:0]   Y2,
    output logic [2*WIDTH-1:0]   Y3,
    output logic [2*WIDTH-1:0]   Y4,
    output logic [2*WIDTH-1:0]   Y5,
    output logic [2*WIDTH-1:0]   Y6,
    output logic [2*WIDTH-1:0]   Y7,
    output logic [2*WIDTH-1:0]   Y8,
    output logic [2*WIDTH-1:0]   Y9,
    output logic [RW-1:0]        w_row,
    output logic [CW-1:0]        w_col,
    output logic                 frame_done
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {LOAD, EMIT} state_t;

    state_t               state;
    logic [WIDTH-1:0]     mem_u [N];
    logic [2*WIDTH-1:0]   mem_y [N];
    logic [IW-1:0]        wr_idx;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        tgt_row;
    logic [CW-1:0]        tgt_col;
    logic [WIDTH-1:0]     win_u_q [9];
    logic [WIDTH-1:0]     win_u_d [9];
    logic [2*WIDTH-1:0]   win_y_q [9];
    logic [2*WIDTH-1:0]   win_y_d [9];
    logic                 load_hs;
    logic                 last_pix;
    logic                 win_hs;
    logic                 last_cell;

    assign s_ready   = (state == LOAD) && !rst;
    assign load_hs   = s_valid && s_ready;
    assign last_pix  = load_hs && (wr_idx == IW'(N - 1));
    assign win_hs    = w_valid && w_ready;
    assign last_cell = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

    assign w_row = row_q;
    assign w_col = col_q;

    assign U1 = win_u_q[0];
    assign U2 = win_u_q[1];
    assign U3 = win_u_q[2];
    assign U4 = win_u_q[3];
    assign U5 = win_u_q[4];
    assign U6 = win_u_q[5];
    assign U7 = win_u_q[6];
    assign U8 = win_u_q[7];
    assign U9 = win_u_q[8];
    assign Y1 = win_y_q[0];
    assign Y2 = win_y_q[1];
    assign Y3 = win_y_q[2];
    assign Y4 = win_y_q[3];
    assign Y5 = win_y_q[4];
    assign Y6 = win_y_q[5];
    assign Y7 = win_y_q[6];
    assign Y8 = win_y_q[7];
    assign Y9 = win_y_q[8];

    // Frame storage, written in raster order while loading
    always_ff @(posedge clk) begin
        if (load_hs) begin
            mem_u[wr_idx] <= s_u;
            mem_y[wr_idx] <= s_y;
        end
    end

    // Centre cell of the window to register next: (0,0) on load completion,
    // otherwise the raster successor of the current centre
    always_comb begin
        tgt_row = row_q;
        tgt_col = col_q;
        if (state == LOAD) begin
            tgt_row = '0;
            tgt_col = '0;
        end else if (col_q == CW'(COLS - 1)) begin
            tgt_row = row_q + RW'(1);
            tgt_col = '0;
        end else begin
            tgt_col = col_q + CW'(1);
        end
    end

    // Gather the 3x3 neighbourhood of the target cell; the pixel being
    // written this cycle is forwarded because the (0,0) window is captured
    // on the same edge that stores the final pixel
    always_comb begin
        for (int unsigned k = 0; k < 9; k++) begin
            int nr;
            int nc;
            logic [IW-1:0] idx;
            nr = int'(tgt_row) + int'(k / 3) - 1;
            nc = int'(tgt_col) + int'(k % 3) - 1;
            idx = '0;
            win_u_d[k] = BOUND_U;
            win_y_d[k] = BOUND_Y;
            if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
                idx = IW'(nr * COLS + nc);
                if (load_hs && idx == wr_idx) begin
                    win_u_d[k] = s_u;
                    win_y_d[k] = s_y;
                end else begin
                    win_u_d[k] = mem_u[idx];
                    win_y_d[k] = mem_y[idx];
                end
            end
        end
    end

    // LOAD/EMIT control with registered window outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            wr_idx     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            w_valid    <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned k = 0; k < 9; k++) begin
                win_u_q[k] <= '0;
                win_y_q[k] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        if (last_pix) begin
                            state   <= EMIT;
                            wr_idx  <= '0;
                            w_valid <= 1'b1;
                            row_q   <= tgt_row;
                            col_q   <= tgt_col;
                            win_u_q <= win_u_d;
                            win_y_q <= win_y_d;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (win_hs) begin
                        if (last_cell) begin
                            state      <= LOAD;
                            w_valid    <= 1'b0;
                            frame_done <= 1'b1;
                            wr_idx     <= '0;
                        end else begin
                            row_q   <= tgt_row;
                            col_q   <= tgt_col;
                            win_u_q <= win_u_d;
                            win_y_q <= win_y_d;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: drives a 3x3 instance (zero boundary) and a 1x4
// instance (negative boundary) and compares every emitted window against a
// neighbourhood model computed from the frame contents.
module tb_cnn_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        i_sv, i_wr;
    logic [8:0]  i_su;
    logic [17:0] i_sy;

    logic        a_sv, a_wr, a_sr, a_wv, a_fd;
    logic [8:0]  a_u [9];
    logic [17:0] a_y [9];
    logic [1:0]  a_row, a_col;

    logic        b_sv, b_wr, b_sr, b_wv, b_fd;
    logic [8:0]  b_u [9];
    logic [17:0] b_y [9];
    logic [0:0]  b_row;
    logic [1:0]  b_col;

    logic        o_sr, o_wv, o_fd;
    logic [8:0]  o_u [9];
    logic [17:0] o_y [9];
    int          o_row, o_col;

    always_comb begin
        a_sv = (sel == 0) ? i_sv : 1'b0;
        a_wr = (sel == 0) ? i_wr : 1'b0;
        b_sv = (sel == 1) ? i_sv : 1'b0;
        b_wr = (sel == 1) ? i_wr : 1'b0;
        o_sr  = (sel == 0) ? a_sr : b_sr;
        o_wv  = (sel == 0) ? a_wv : b_wv;
        o_fd  = (sel == 0) ? a_fd : b_fd;
        o_row = (sel == 0) ? int'(a_row) : int'(b_row);
        o_col = (sel == 0) ? int'(a_col) : int'(b_col);
        for (int k = 0; k < 9; k++) begin
            o_u[k] = (sel == 0) ? a_u[k] : b_u[k];
            o_y[k] = (sel == 0) ? a_y[k] : b_y[k];
        end
    end

    cnn_window_gen #(.WIDTH(9), .ROWS(3), .COLS(3)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_sv), .s_ready(a_sr), .s_u(i_su), .s_y(i_sy),
        .w_valid(a_wv), .w_ready(a_wr),
        .U1(a_u[0]), .U2(a_u[1]), .U3(a_u[2]), .U4(a_u[3]), .U5(a_u[4]),
        .U6(a_u[5]), .U7(a_u[6]), .U8(a_u[7]), .U9(a_u[8]),
        .Y1(a_y[0]), .Y2(a_y[1]), .Y3(a_y[2]), .Y4(a_y[3]), .Y5(a_y[4]),
        .Y6(a_y[5]), .Y7(a_y[6]), .Y8(a_y[7]), .Y9(a_y[8]),
        .w_row(a_row), .w_col(a_col), .frame_done(a_fd)
    );

    cnn_window_gen #(.WIDTH(9), .ROWS(1), .COLS(4), .BOUND_U(9'h1FF), .BOUND_Y(18'h3FFFE)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_sv), .s_ready(b_sr), .s_u(i_su), .s_y(i_sy),
        .w_valid(b_wv), .w_ready(b_wr),
        .U1(b_u[0]), .U2(b_u[1]), .U3(b_u[2]), .U4(b_u[3]), .U5(b_u[4]),
        .U6(b_u[5]), .U7(b_u[6]), .U8(b_u[7]), .U9(b_u[8]),
        .Y1(b_y[0]), .Y2(b_y[1]), .Y3(b_y[2]), .Y4(b_y[3]), .Y5(b_y[4]),
        .Y6(b_y[5]), .Y7(b_y[6]), .Y8(b_y[7]), .Y9(b_y[8]),
        .w_row(b_row), .w_col(b_col), .frame_done(b_fd)
    );

    // Reference frame and geometry of the instance under test
    logic [8:0]  fu [16];
    logic [17:0] fy [16];
    int          rows, cols;
    logic [8:0]  bu;
    logic [17:0] by;

    int vec  = 0;
    int miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] m_u(input int r, input int c, input int k);
        int nr = r + k / 3 - 1;
        int nc = c + k % 3 - 1;
        if (nr < 0 || nr >= rows || nc < 0 || nc >= cols) return bu;
        return fu[nr * cols + nc];
    endfunction

    function automatic logic [17:0] m_y(input int r, input int c, input int k);
        int nr = r + k / 3 - 1;
        int nc = c + k % 3 - 1;
        if (nr < 0 || nr >= rows || nc < 0 || nc >= cols) return by;
        return fy[nr * cols + nc];
    endfunction

    task automatic load_frame(input bit gaps);
        int idx = 0;
        while (idx < rows * cols) begin
            @(negedge clk);
            chk("s_ready_load", o_sr, 1);
            chk("w_valid_load", o_wv, 0);
            i_sv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_su = fu[idx];
            i_sy = fy[idx];
            i_wr = 1'($urandom_range(0, 1));
            if (i_sv) idx++;
        end
    endtask

    task automatic emit_frame(input int rdy_pct, input bit sv_on, input int stop_after);
        int e = 0;
        int hs = 0;
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            chk("w_valid_emit", o_wv, 1);
            chk("s_ready_emit", o_sr, 0);
            chk("frame_done_mid", o_fd, 0);
            chk($sformatf("w_row@%0d", e), o_row, e / cols);
            chk($sformatf("w_col@%0d", e), o_col, e % cols);
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("U%0d@%0d", k + 1, e), o_u[k], m_u(e / cols, e % cols, k));
                chk($sformatf("Y%0d@%0d", k + 1, e), o_y[k], m_y(e / cols, e % cols, k));
            end
            i_sv = sv_on;
            i_su = 9'($urandom);
            i_sy = 18'($urandom);
            i_wr = ($urandom_range(0, 99) < rdy_pct);
            if (i_wr) begin
                hs++;
                if (e == rows * cols - 1 || hs == stop_after) done = 1;
                else e++;
            end
        end
        chk("emit_complete", done, 1);
    endtask

    task automatic post_frame();
        @(negedge clk);
        i_sv = 1'b0;
        i_wr = 1'b0;
        chk("frame_done_pulse", o_fd, 1);
        chk("w_valid_after", o_wv, 0);
        chk("s_ready_after", o_sr, 1);
        @(negedge clk);
        chk("frame_done_clear", o_fd, 0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_w_valid"}, o_wv, 0);
        chk({tag, "_frame_done"}, o_fd, 0);
        chk({tag, "_s_ready"}, o_sr, 0);
        chk({tag, "_w_row"}, o_row, 0);
        chk({tag, "_w_col"}, o_col, 0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_U%0d", tag, k + 1), o_u[k], 0);
            chk($sformatf("%s_Y%0d", tag, k + 1), o_y[k], 0);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) begin
            fu[k] = 9'($urandom);
            fy[k] = 18'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 0;
        i_sv = 1'b0; i_wr = 1'b0; i_su = '0; i_sy = '0;
        repeat (3) @(negedge clk);
        reset_outputs("rst_a");
        sel = 1;
        #1;
        reset_outputs("rst_b");
        sel = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_release", o_sr, 1);

        // 3x3, zero boundary: U=1..9, Y=10..90, continuous ready
        rows = 3; cols = 3; bu = '0; by = '0;
        for (int k = 0; k < 9; k++) begin
            fu[k] = 9'(k + 1);
            fy[k] = 18'(10 * (k + 1));
        end
        load_frame(0);
        emit_frame(100, 0, 0);
        post_frame();

        // U=-k, random backpressure, s_valid held high during replay
        for (int k = 0; k < 9; k++) begin
            fu[k] = 9'(-(k + 1));
            fy[k] = 18'($urandom);
        end
        load_frame(1);
        emit_frame(50, 1, 0);
        post_frame();

        // Reset after the 4th window handshake, then a fresh frame
        rand_frame();
        load_frame(1);
        emit_frame(100, 0, 4);
        @(negedge clk);
        rst = 1'b1;
        i_sv = 1'b0;
        i_wr = 1'b0;
        @(negedge clk);
        reset_outputs("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", o_sr, 1);
        chk("w_valid_after_rst", o_wv, 0);
        rand_frame();
        load_frame(1);
        emit_frame(60, 1, 0);
        post_frame();

        // 1x4 with negative boundary values and a sign-extreme Y
        sel = 1;
        rows = 1; cols = 4; bu = 9'h1FF; by = 18'h3FFFE;
        rand_frame();
        for (int k = 0; k < 4; k++) fu[k] = 9'(k + 1);
        fy[0] = 18'h3FFFF;
        load_frame(1);
        emit_frame(70, 1, 0);
        post_frame();
        rand_frame();
        load_frame(1);
        emit_frame(40, 1, 0);
        post_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
